// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus with a programmable all-z turnaround gap.
// Optional per-owner burst limit is enabled by defining TRIBUS_BURST_LIMIT_EN.
module tristate_bus_arbiter #(
    parameter int WIDTH      = 4,
    parameter int NCH        = 2,
    parameter int TURNAROUND = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*WIDTH-1:0]   d,
    output logic [NCH-1:0]         grant,
    output logic                   valid,
    output logic [WIDTH-1:0]       y
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t           state_reg, state_next;
    logic [NCH-1:0]   grant_reg, grant_next;
    logic [PW-1:0]    owner_reg, owner_next;
    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [3:0]       cnt_reg, cnt_next;

    logic             release_owner;
    logic             do_arb;
    logic             found;
    logic [PW-1:0]    win;
    logic [NCH-1:0]   arb_mask;
    int               idx;

    logic [WIDTH-1:0] masked [NCH];
    logic [WIDTH-1:0] owner_word;

`ifdef TRIBUS_BURST_LIMIT_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_reg, burst_next;
    logic          at_limit;

    assign at_limit = (burst_reg == BW'(MAX_BURST));
    // Preempt only when someone else is actually waiting for the bus.
    assign release_owner = !req[owner_reg] || (at_limit && |(req & ~grant_reg));
`else
    assign release_owner = !req[owner_reg];
`endif

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        arb_mask   = req;
        do_arb     = 1'b0;
        found      = 1'b0;
        win        = '0;
        idx        = 0;
`ifdef TRIBUS_BURST_LIMIT_EN
        burst_next = burst_reg;
`endif
        case (state_reg)
            IDLE: do_arb = 1'b1;
            DRIVE: begin
                if (release_owner) begin
                    grant_next = '0;
                    if (TURNAROUND > 0) begin
                        state_next = TURN;
                        cnt_next   = 4'(TURNAROUND - 1);
                    end else begin
                        arb_mask = req & ~grant_reg;
                        do_arb   = 1'b1;
                    end
                end else begin
`ifdef TRIBUS_BURST_LIMIT_EN
                    burst_next = at_limit ? BW'(1) : burst_reg + 1'b1;
`endif
                end
            end
            TURN: begin
                if (cnt_reg == 4'd0) begin
                    do_arb = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // First requester at or after the pointer wins, wrapping to channel 0.
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && arb_mask[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end

        if (do_arb) begin
            if (found) begin
                grant_next      = '0;
                grant_next[win] = 1'b1;
                owner_next      = win;
                ptr_next        = (win == PW'(NCH - 1)) ? '0 : win + 1'b1;
                state_next      = DRIVE;
`ifdef TRIBUS_BURST_LIMIT_EN
                burst_next      = BW'(1);
`endif
            end else begin
                grant_next = '0;
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
`ifdef TRIBUS_BURST_LIMIT_EN
            burst_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
`ifdef TRIBUS_BURST_LIMIT_EN
            burst_reg <= burst_next;
`endif
        end
    end

    // The grant is one-hot, so an AND-OR select is enough to pick the owner's word.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_sel
            assign masked[gi] = {WIDTH{grant_reg[gi]}} & d[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        owner_word = '0;
        for (int i = 0; i < NCH; i++) owner_word = owner_word | masked[i];
    end

    assign grant = grant_reg;
    assign valid = |grant_reg;
    assign y     = valid ? owner_word : {WIDTH{1'bz}};

endmodule
